// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions: default generator polynomial, transmit FSM states
// and the bytewise CRC step used by both the appender and checker models.
package crc8_pkg;

  localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;

  typedef enum logic [1:0] {IDLE, BODY, TAIL} crc8_tx_state_t;

  // One byte of MSB-first CRC-8: fold the byte into the register, then shift
  // eight times, reducing by the polynomial whenever the top bit falls out.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc,
                                           input logic [7:0] data,
                                           input logic [7:0] poly);
    logic [7:0] c;
    c = crc ^ data;
    for (int b = 0; b < 8; b++) begin
      if (c[7]) c = {c[6:0], 1'b0} ^ poly;
      else      c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/crc8_tx_appender.sv
// CRC-8 transmit appender: forwards a byte stream unchanged through a single
// output register and appends the frame CRC as the new last byte.
// Optional macro CRC8_TX_ERRINJ_EN adds i_err_inj, which flips bit 0 of the
// emitted CRC byte (o_crc8 still reports the true CRC).
module crc8_tx_appender
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLY   = CRC8_POLY_DEFAULT,
  parameter logic [7:0] INIT   = 8'h00,
  parameter logic [7:0] XOROUT = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_valid,
  input  logic       i_last,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_valid,
  output logic       o_last,
  output logic [7:0] o_data,
  input  logic       i_ready,
`ifdef CRC8_TX_ERRINJ_EN
  input  logic       i_err_inj,
`endif
  output logic [7:0] o_crc8,
  output logic       o_done
);

  crc8_tx_state_t state;
  logic [7:0]     crc;
  logic [7:0]     crc_next;
  logic [7:0]     crc_final;
  logic [7:0]     tail_byte;
  logic           slot_free;
  logic           accept;

  // The output register can take a new byte when empty or being drained now.
  assign slot_free = !o_valid || i_ready;
  // Input is held off while the CRC byte waits for the output slot.
  assign o_ready   = !reset && slot_free && (state != TAIL);
  assign accept    = i_valid && o_ready;
  assign crc_next  = crc8_byte(crc, i_data, POLY);
  assign crc_final = crc ^ XOROUT;

`ifdef CRC8_TX_ERRINJ_EN
  logic inj_pend;

  // Capture the injection request alongside the last payload byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inj_pend <= 1'b0;
    end else if (accept && i_last) begin
      inj_pend <= i_err_inj;
    end else if (state == TAIL && slot_free) begin
      inj_pend <= 1'b0;
    end
  end

  assign tail_byte = crc_final ^ {7'b0, inj_pend};
`else
  assign tail_byte = crc_final;
`endif

  // Frame FSM, running CRC and the output register advance together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      crc     <= INIT;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_data  <= 8'h00;
      o_crc8  <= 8'h00;
      o_done  <= 1'b0;
    end else begin
      o_done <= o_valid && o_last && i_ready;
      if (slot_free) begin
        if (state == TAIL) begin
          o_data  <= tail_byte;
          o_last  <= 1'b1;
          o_valid <= 1'b1;
          o_crc8  <= crc_final;
          crc     <= INIT;
          state   <= IDLE;
        end else if (accept) begin
          o_data  <= i_data;
          o_last  <= 1'b0;
          o_valid <= 1'b1;
          crc     <= crc_next;
          state   <= i_last ? TAIL : BODY;
        end else begin
          o_valid <= 1'b0;
          o_last  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_crc8_tx_appender.sv
// Directed bench for crc8_tx_appender: known CRC-8 vectors, back-to-back
// single-byte frames, output backpressure, mid-frame reset and a checker
// model fed from the output stream.
module tb_crc8_tx_appender;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_valid = 1'b0;
  logic       i_last = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_ready = 1'b1;
  logic       o_ready, o_valid, o_last, o_done;
  logic [7:0] o_data, o_crc8;
`ifdef CRC8_TX_ERRINJ_EN
  logic       i_err_inj = 1'b0;
`endif

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  bit   toggle = 1'b0;
  bit   mon_on = 1'b0;
  bit   tail_win = 1'b0;

  logic [7:0] pay[$];
  logic [7:0] cap_data[$];
  bit         cap_last[$];
  int         cap_cyc[$];

  always #5 clk = ~clk;

  crc8_tx_appender dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_last(i_last), .i_data(i_data),
    .o_ready(o_ready), .o_valid(o_valid), .o_last(o_last), .o_data(o_data),
    .i_ready(i_ready),
`ifdef CRC8_TX_ERRINJ_EN
    .i_err_inj(i_err_inj),
`endif
    .o_crc8(o_crc8), .o_done(o_done)
  );

  // Bit-serial reference CRC-8, polynomial 0x07.
  function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic fb;
    r = c;
    for (int b = 7; b >= 0; b--) begin
      fb = r[7] ^ d[b];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: records handshakes, checks stall stability and input blocking.
  initial begin
    bit         prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_on && !reset) begin
        if (prev_stall) begin
          n_cmp++;
          if (o_valid !== 1'b1 || o_data !== prev_data || o_last !== prev_last) begin
            n_fail++;
            $display("FAIL stall_hold: got valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                     o_valid, o_data, o_last, prev_data, prev_last);
          end
        end
        if (tail_win && !(o_valid && o_last)) begin
          n_cmp++;
          if (o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL tail_blocks_input: got o_ready=%b, want 0", o_ready);
          end
        end
        if (o_valid && o_last) tail_win = 1'b0;
        if (i_valid && o_ready && i_last) tail_win = 1'b1;
        if (o_valid && i_ready) begin
          cap_data.push_back(o_data);
          cap_last.push_back(o_last);
          cap_cyc.push_back(cyc);
        end
        if (o_done) done_cnt++;
        prev_stall = o_valid && !i_ready;
        prev_data  = o_data;
        prev_last  = o_last;
      end else begin
        prev_stall = 1'b0;
        tail_win   = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (toggle) i_ready = ~i_ready;
  endtask

  task automatic clear_cap();
    cap_data.delete();
    cap_last.delete();
    cap_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic send_frame(input int n, input bit with_last, input bit inj);
    int i = 0;
    int g = 0;
    while (i < n && g < 500) begin
      i_valid = 1'b1;
      i_data  = pay[i];
      i_last  = with_last && (i == n - 1);
`ifdef CRC8_TX_ERRINJ_EN
      i_err_inj = inj && i_last;
`endif
      @(negedge clk);
      if (o_ready) i++;
      step();
      g++;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_data  = 8'h00;
`ifdef CRC8_TX_ERRINJ_EN
    i_err_inj = 1'b0;
`endif
    n_cmp++;
    if (i < n) begin
      n_fail++;
      $display("FAIL send_timeout: got %0d bytes accepted, want %0d", i, n);
    end
  endtask

  task automatic wait_out(input int n);
    int g = 0;
    while (cap_data.size() < n && g < 300) begin
      step();
      g++;
    end
    repeat (3) step();
    n_cmp++;
    if (cap_data.size() != n) begin
      n_fail++;
      $display("FAIL out_count: got %0d bytes, want %0d", cap_data.size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_cmp += 6;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_o_valid: got %b want 0", o_valid); end
    if (o_last !== 1'b0) begin n_fail++; $display("FAIL rst_o_last: got %b want 0", o_last); end
    if (o_data !== 8'h00) begin n_fail++; $display("FAIL rst_o_data: got %h want 00", o_data); end
    if (o_crc8 !== 8'h00) begin n_fail++; $display("FAIL rst_o_crc8: got %h want 00", o_crc8); end
    if (o_done !== 1'b0) begin n_fail++; $display("FAIL rst_o_done: got %b want 0", o_done); end
    if (o_ready !== 1'b0) begin n_fail++; $display("FAIL rst_o_ready: got %b want 0", o_ready); end
    reset = 1'b0;
    step();
    n_cmp++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b want 1", o_ready); end
    mon_on = 1'b1;
  endtask

  task automatic test_nine_byte(input bit stall);
    logic [7:0] exp[10];
    exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
    pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    clear_cap();
    toggle = stall;
    send_frame(9, 1'b1, 1'b0);
    wait_out(10);
    toggle  = 1'b0;
    i_ready = 1'b1;
    step();
    for (int k = 0; k < 10 && k < cap_data.size(); k++) begin
      n_cmp++;
      if (cap_data[k] !== exp[k] || cap_last[k] !== (k == 9)) begin
        n_fail++;
        $display("FAIL nine_byte[%0d] stall=%0d: got %h last=%b, want %h last=%b",
                 k, stall, cap_data[k], cap_last[k], exp[k], (k == 9));
      end
    end
    if (!stall && cap_cyc.size() == 10) begin
      n_cmp++;
      if (cap_cyc[9] - cap_cyc[0] != 9) begin
        n_fail++;
        $display("FAIL nine_byte_throughput: got span %0d cycles, want 9", cap_cyc[9] - cap_cyc[0]);
      end
    end
    n_cmp += 2;
    if (o_crc8 !== 8'hF4) begin n_fail++; $display("FAIL nine_byte_crc8: got %h want F4", o_crc8); end
    if (done_cnt != 1) begin n_fail++; $display("FAIL nine_byte_done: got %0d pulses want 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[4];
    bit         expl[4];
    exp  = '{8'h01, 8'h07, 8'hFF, 8'hF3};
    expl = '{1'b0, 1'b1, 1'b0, 1'b1};
    clear_cap();
    pay = '{8'h01};
    send_frame(1, 1'b1, 1'b0);
    pay = '{8'hFF};
    send_frame(1, 1'b1, 1'b0);
    wait_out(4);
    for (int k = 0; k < 4 && k < cap_data.size(); k++) begin
      n_cmp++;
      if (cap_data[k] !== exp[k] || cap_last[k] !== expl[k]) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got %h last=%b, want %h last=%b", k, cap_data[k], cap_last[k], exp[k], expl[k]);
      end
    end
    if (cap_cyc.size() == 4) begin
      n_cmp++;
      if (cap_cyc[3] - cap_cyc[0] != 3) begin
        n_fail++;
        $display("FAIL b2b_gap: got span %0d cycles, want 3", cap_cyc[3] - cap_cyc[0]);
      end
    end
    n_cmp += 2;
    if (o_crc8 !== 8'hF3) begin n_fail++; $display("FAIL b2b_crc8: got %h want F3", o_crc8); end
    if (done_cnt != 2) begin n_fail++; $display("FAIL b2b_done: got %0d pulses want 2", done_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    pay = '{8'h31, 8'h32, 8'h33, 8'h34};
    clear_cap();
    send_frame(4, 1'b0, 1'b0);
    step();
    mon_on = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_cmp += 3;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %b want 0", o_valid); end
    if (o_ready !== 1'b0) begin n_fail++; $display("FAIL async_rst_ready: got %b want 0", o_ready); end
    if (o_crc8 !== 8'h00) begin n_fail++; $display("FAIL async_rst_crc8: got %h want 00", o_crc8); end
    step();
    step();
    reset = 1'b0;
    clear_cap();
    mon_on = 1'b1;
    repeat (5) step();
    n_cmp++;
    if (cap_data.size() != 0) begin
      n_fail++;
      $display("FAIL aborted_no_crc: got %0d output bytes, want 0", cap_data.size());
    end
    pay = '{8'h00};
    send_frame(1, 1'b1, 1'b0);
    wait_out(2);
    if (cap_data.size() == 2) begin
      n_cmp += 2;
      if (cap_data[0] !== 8'h00 || cap_last[0] !== 1'b0) begin
        n_fail++; $display("FAIL post_abort_b0: got %h last=%b, want 00 last=0", cap_data[0], cap_last[0]);
      end
      if (cap_data[1] !== 8'h00 || cap_last[1] !== 1'b1) begin
        n_fail++; $display("FAIL post_abort_b1: got %h last=%b, want 00 last=1", cap_data[1], cap_last[1]);
      end
    end
    n_cmp += 2;
    if (o_crc8 !== 8'h00) begin n_fail++; $display("FAIL post_abort_crc8: got %h want 00", o_crc8); end
    if (done_cnt != 1) begin n_fail++; $display("FAIL post_abort_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_checker_chain();
    for (int f = 0; f < 4; f++) begin
      int len;
      logic [7:0] exp_crc;
      logic [7:0] resid;
      bit ok;
      len = $urandom_range(1, 16);
      pay.delete();
      exp_crc = 8'h00;
      for (int k = 0; k < len; k++) begin
        pay.push_back(8'($urandom_range(0, 255)));
        exp_crc = ref_crc(exp_crc, pay[k]);
      end
      clear_cap();
      send_frame(len, 1'b1, 1'b0);
      wait_out(len + 1);
      ok = (cap_data.size() == len + 1);
      resid = 8'h00;
      for (int k = 0; k < cap_data.size(); k++) begin
        resid = ref_crc(resid, cap_data[k]);
        if (k < len && (cap_data[k] !== pay[k] || cap_last[k] !== 1'b0)) ok = 1'b0;
        if (k == len && (cap_data[k] !== exp_crc || cap_last[k] !== 1'b1)) ok = 1'b0;
      end
      n_cmp += 4;
      if (!ok) begin n_fail++; $display("FAIL chain%0d_stream: len=%0d got %0d bytes, want payload+%h", f, len, cap_data.size(), exp_crc); end
      if (resid !== 8'h00) begin n_fail++; $display("FAIL chain%0d_match: got residue %h want 00", f, resid); end
      if (o_crc8 !== exp_crc) begin n_fail++; $display("FAIL chain%0d_crc8: got %h want %h", f, o_crc8, exp_crc); end
      if (done_cnt != 1) begin n_fail++; $display("FAIL chain%0d_done: got %0d want 1", f, done_cnt); end
    end
  endtask

`ifdef CRC8_TX_ERRINJ_EN
  task automatic test_err_inj();
    logic [7:0] resid;
    pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    clear_cap();
    send_frame(9, 1'b1, 1'b1);
    wait_out(10);
    resid = 8'h00;
    for (int k = 0; k < cap_data.size(); k++) resid = ref_crc(resid, cap_data[k]);
    n_cmp += 3;
    if (cap_data.size() != 10 || cap_data[9] !== 8'hF5) begin
      n_fail++; $display("FAIL errinj_byte: got %0d bytes, want 10 with CRC byte F5", cap_data.size());
    end
    if (o_crc8 !== 8'hF4) begin n_fail++; $display("FAIL errinj_crc8: got %h want F4", o_crc8); end
    if (resid === 8'h00) begin n_fail++; $display("FAIL errinj_nomatch: got residue %h want nonzero", resid); end
  endtask
`endif

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nine_byte(1'b0);
    test_back_to_back();
    test_nine_byte(1'b1);
    test_reset_mid_frame();
    test_checker_chain();
`ifdef CRC8_TX_ERRINJ_EN
    test_err_inj();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
